// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store unit between a single-issue request port and a
// word-wide data memory with combinational read and synchronous write.
// Loads take 2 cycles, word stores 2, byte/half stores 3 (read-merge-write).
// Optional build macro: DMEM_CTRL_MISALIGN_CHECK_EN. When it is defined,
// misaligned half/word accesses complete with rsp_err = 1 and no memory write.
//
// Handshake: a request moves on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, and a request's
// fields are sampled only on that edge. rsp_valid is a one-cycle pulse with
// no backpressure. rsp_rdata and rsp_err keep their value until the next pulse.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state, state_nx;

  // Request fields captured at acceptance. Address bits above the word
  // address are not kept, so accesses wrap inside the memory.
  logic                  r_we;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic [31:0]           r_merged;

  logic        accept;
  logic        rsp_set;
  logic [31:0] rsp_rdata_nx;
  logic        rsp_err_nx;
  logic        merge_load;
  logic        is_word;
  logic        is_half;
  logic        misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  assign accept    = req_valid & req_ready;
  assign is_word   = r_size[1];            // 10 = word, 11 = reserved, treated as word
  assign is_half   = (r_size == 2'b01);
  assign mem_raddr = r_addr[ADDR_WIDTH+1:2];
  assign mem_waddr = r_addr[ADDR_WIDTH+1:2];
  assign dbg_state = state;

`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
  assign misaligned = (is_half & r_addr[0]) | (is_word & (r_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Pick the addressed lane from the read word and extend it to 32 bits.
  always_comb begin
    lane_byte = 8'h00;
    load_data = 32'h0;
    case (r_addr[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_word) begin
      load_data = mem_rdata;
    end else if (is_half) begin
      load_data = {{16{~r_unsigned & lane_half[15]}}, lane_half};
    end else begin
      load_data = {{24{~r_unsigned & lane_byte[7]}}, lane_byte};
    end
  end

  // Overlay the store data onto the current memory word for sub-word stores.
  always_comb begin
    merged_word = mem_rdata;
    if (is_half) begin
      if (r_addr[1]) merged_word[31:16] = r_wdata[15:0];
      else           merged_word[15:0]  = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'd0: merged_word[7:0]   = r_wdata[7:0];
        2'd1: merged_word[15:8]  = r_wdata[7:0];
        2'd2: merged_word[23:16] = r_wdata[7:0];
        2'd3: merged_word[31:24] = r_wdata[7:0];
        default: merged_word = mem_rdata;
      endcase
    end
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, memory strobes and response staging.
  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    mem_wen      = 1'b0;
    mem_wdata    = 32'h0;
    rsp_set      = 1'b0;
    rsp_rdata_nx = 32'h0;
    rsp_err_nx   = 1'b0;
    merge_load   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        if (misaligned) begin
          rsp_set    = 1'b1;
          rsp_err_nx = 1'b1;
          state_nx   = IDLE;
        end else if (!r_we) begin
          rsp_set      = 1'b1;
          rsp_rdata_nx = load_data;
          state_nx     = IDLE;
        end else if (is_word) begin
          mem_wen   = 1'b1;
          mem_wdata = r_wdata;
          rsp_set   = 1'b1;
          state_nx  = IDLE;
        end else begin
          merge_load = 1'b1;
          state_nx   = WRITE;
        end
      end
      WRITE: begin
        mem_wen   = 1'b1;
        mem_wdata = r_merged;
        rsp_set   = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, merge register and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'h0;
      r_merged   <= 32'h0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= rsp_set;
      if (rsp_set) begin
        rsp_rdata <= rsp_rdata_nx;
        rsp_err   <= rsp_err_nx;
      end
      if (accept) begin
        r_we       <= req_we;
        r_addr     <= req_addr[ADDR_WIDTH+1:0];
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end
      if (merge_load) r_merged <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, hand-written multi-cycle
// sequences, then random requests checked against a byte-array memory model.
module tb_dmem_ctrl;

  localparam int AW = 12;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic [1:0]    dbg_state;

  logic          do_seed;
  logic [31:0]   mem [0:NW-1];
  logic [7:0]    ref_b [0:4*NW-1];
  int            wen_count = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = mem[mem_raddr];

  always @(posedge clk) begin
    if (do_seed) begin
      for (int i = 0; i < NW; i++) mem[i] <= seed_word(i);
    end else if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
      wen_count <= wen_count + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Byte-addressed reference: little-endian, natural alignment by access size.
  task automatic model_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
    int n;
    int base;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = 1'b0;
`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    if ((int'(addr[1:0]) % n) != 0) err = 1'b1;
`endif
    base = int'(addr[AW+1:0]);
    base = base - (base % n);
    rdata = 32'h0;
    lat = 2;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_b[base+i] = wdata[8*i +: 8];
      if (n < 4) lat = 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[base+i];
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      rdata = v;
    end
  endtask

  // ---------------- driver ----------------
  // Starts and ends just after a falling edge. lat counts cycles from the
  // accepting edge to the rsp_valid cycle (-1 on timeout).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int wens);
    int k;
    int w0;
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    rdata = 32'h0; err = 1'b0; lat = -1; wens = 0;
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    w0 = wen_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rdata = rsp_rdata;
    err = rsp_err;
    wens = wen_count - w0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          wn;
    logic [31:0] m_rd;
    logic        m_er;
    int          m_lt;
    logic [31:0] old;
    int          w0;
    int          seen;
    int          bad;

    vecs[0]  = '{1'b0, 32'h41,       2'd0, 1'b0, 32'h0,        32'hFFFFFFAA, 2};
    vecs[1]  = '{1'b0, 32'h41,       2'd0, 1'b1, 32'h0,        32'h000000AA, 2};
    vecs[2]  = '{1'b0, 32'h40,       2'd2, 1'b0, 32'h0,        32'h5C99AABB, 2};
    vecs[3]  = '{1'b0, 32'h40,       2'd1, 1'b0, 32'h0,        32'hFFFFAABB, 2};
    vecs[4]  = '{1'b0, 32'h42,       2'd1, 1'b0, 32'h0,        32'h00005C99, 2};
    vecs[5]  = '{1'b0, 32'h43,       2'd0, 1'b0, 32'h0,        32'h0000005C, 2};
    vecs[6]  = '{1'b1, 32'h46,       2'd1, 1'b0, 32'h1234BEEF, 32'h0,        3};
    vecs[7]  = '{1'b0, 32'h46,       2'd1, 1'b1, 32'h0,        32'h0000BEEF, 2};
    vecs[8]  = '{1'b0, 32'h46,       2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 2};
    vecs[9]  = '{1'b1, 32'h44,       2'd0, 1'b0, 32'hFFFFFF80, 32'h0,        3};
    vecs[10] = '{1'b0, 32'h44,       2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 2};
    vecs[11] = '{1'b1, 32'h00004000, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        2};
    vecs[12] = '{1'b0, 32'h0,        2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 2};
    vecs[13] = '{1'b0, 32'h0,        2'd3, 1'b0, 32'h0,        32'hCAFEF00D, 2};
    vecs[14] = '{1'b0, 32'h3,        2'd0, 1'b1, 32'h0,        32'h000000CA, 2};
    vecs[15] = '{1'b0, 32'h2,        2'd1, 1'b0, 32'h0,        32'hFFFFCAFE, 2};

    for (int w = 0; w < NW; w++) begin
      old = seed_word(w);
      for (int b = 0; b < 4; b++) ref_b[4*w+b] = old[8*b +: 8];
    end

    // reset
    rst = 1'b1; do_seed = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
    @(negedge clk);
    do_seed = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_wen", 32'(mem_wen), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);

    // back-to-back: word store then half load, req_valid held high
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h12345678;
    chk("b2b_ready0", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'hA; req_size = 2'd1; req_unsigned = 1'b1; req_wdata = $urandom;
    chk("b2b_busy", {30'h0, rsp_valid, req_ready}, 32'h0);
    @(negedge clk);
    chk("b2b_rsp1", {30'h0, rsp_valid, req_ready}, 32'h3);
    chk("b2b_rsp1_data", rsp_rdata, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_gap", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("b2b_rsp2", 32'(rsp_valid), 32'h1);
    chk("b2b_load_data", rsp_rdata, 32'h00001234);
    model_req(1'b1, 32'h8, 2'd2, 1'b0, 32'h12345678, m_rd, m_er, m_lt);

    // byte store read-modify-write timing
    do_req(1'b1, 32'h40, 2'd2, 1'b0, 32'h8899AABB, rd, er, lt, wn);
    model_req(1'b1, 32'h40, 2'd2, 1'b0, 32'h8899AABB, m_rd, m_er, m_lt);
    chk("w40_lat", 32'(lt), 32'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h43; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0000005C;
    chk("sb_ready", 32'(req_ready), 32'h1);
    w0 = wen_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sb_wen_access", 32'(mem_wen), 32'h0);
    @(negedge clk);
    chk("sb_wen_write", 32'(mem_wen), 32'h1);
    chk("sb_waddr", 32'(mem_waddr), 32'h010);
    chk("sb_wdata", mem_wdata, 32'h5C99AABB);
    chk("sb_no_rsp_yet", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("sb_rsp", {30'h0, rsp_valid, mem_wen}, 32'h2);
    chk("sb_rdata", rsp_rdata, 32'h0);
    chk("sb_wen_pulses", 32'(wen_count - w0), 32'd1);
    model_req(1'b1, 32'h43, 2'd0, 1'b0, 32'h0000005C, m_rd, m_er, m_lt);

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er, lt, wn);
      model_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, m_rd, m_er, m_lt);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'h0);
      chk($sformatf("vec%0d_lat", i), 32'(lt), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_wen", i), 32'(wn), vecs[i].we ? 32'd1 : 32'd0);
    end

    // reset while a half store sits in WRITE
    old = mem[8];
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h22; req_size = 2'd1;
    req_unsigned = 1'b0; req_wdata = 32'h00007777;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rw_in_write", 32'(mem_wen), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rw_wen_drop", 32'(mem_wen), 32'h0);
    chk("rw_rsp_clear", {30'h0, rsp_valid, rsp_err}, 32'h0);
    chk("rw_rdata_clear", rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_ready_after", 32'(req_ready), 32'h1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rw_no_rsp", 32'(seen), 32'd0);
    chk("rw_mem_kept", mem[8], old);

    // misaligned word store
    old = mem[1];
    do_req(1'b1, 32'h6, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lt, wn);
    model_req(1'b1, 32'h6, 2'd2, 1'b0, 32'hDEADBEEF, m_rd, m_er, m_lt);
    chk("mis_lat", 32'(lt), 32'd2);
    chk("mis_rdata", rd, 32'h0);
`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    chk("mis_err", 32'(er), 32'h1);
    chk("mis_wen", 32'(wn), 32'd0);
    chk("mis_mem", mem[1], old);
`else
    chk("mis_err", 32'(er), 32'h0);
    chk("mis_wen", 32'(wn), 32'd1);
    chk("mis_mem", mem[1], 32'hDEADBEEF);
`endif

    // random traffic against the byte-array model
    for (int t = 0; t < 300; t++) begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [1:0]  r_size;
      logic        r_uns;
      logic [31:0] r_wd;
      r_we = 1'($urandom);
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr = (r_addr & 32'hFFFFC000) | 32'($urandom_range(0, 63));
      r_size = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom);
      r_wd = $urandom;
      model_req(r_we, r_addr, r_size, r_uns, r_wd, m_rd, m_er, m_lt);
      do_req(r_we, r_addr, r_size, r_uns, r_wd, rd, er, lt, wn);
      chk($sformatf("rnd%0d_rdata", t), rd, m_rd);
      chk($sformatf("rnd%0d_err", t), 32'(er), 32'(m_er));
      chk($sformatf("rnd%0d_lat", t), 32'(lt), 32'(m_lt));
      chk($sformatf("rnd%0d_wen", t), 32'(wn), (r_we && !m_er) ? 32'd1 : 32'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // final memory image
    bad = 0;
    for (int w = 0; w < NW; w++) begin
      if (mem[w] !== ref_word(w)) begin
        if (bad < 4) $display("memory word 0x%03h differs: 0x%08h vs model 0x%08h", w, mem[w], ref_word(w));
        bad++;
      end
    end
    chk("mem_final_bad_words", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, the data-memory word-address width.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port req_valid, input, 1, a load/store request is present.
REQ-005 The block SHALL have port req_ready, output, 1, the request is accepted this cycle when req_valid is also high.
REQ-006 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_addr, input, 32, the byte address.
REQ-008 The block SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
REQ-009 The block SHALL have port req_unsigned, input, 1, which zero-extends loads when 1 and sign-extends them when 0.
REQ-010 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, a one-cycle completion pulse with no backpressure.
REQ-012 The block SHALL have port rsp_rdata, output, 32, the formatted load data; it is 0 for stores.
REQ-013 The block SHALL have port rsp_err, output, 1, the misaligned-access flag.
REQ-014 The block SHALL have port mem_wen, output, 1, the memory write enable.
REQ-015 The block SHALL have port mem_waddr, output, ADDR_WIDTH, the memory write word address.
REQ-016 The block SHALL have port mem_wdata, output, 32, the memory write data.
REQ-017 The block SHALL have port mem_raddr, output, ADDR_WIDTH, the memory read word address.
REQ-018 The block SHALL have port mem_rdata, input, 32, the memory's combinational read data.

Function
REQ-019 The FSM SHALL have exactly three states (IDLE, ACCESS, WRITE), with req_ready = 1 only in IDLE.
REQ-020 On acceptance (req_valid & req_ready), the block SHALL register we, addr, size, unsigned and wdata, then enter ACCESS.
REQ-021 mem_raddr and mem_waddr SHALL both equal registered addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so accesses wrap.
REQ-022 Load in ACCESS: the block SHALL extract the lane (byte = addr[1:0], half = addr[1]), extend it per unsigned, register it to rsp_rdata, and return to IDLE; rsp_valid is high in the cycle after ACCESS (acceptance + 2).
REQ-023 Word store in ACCESS: the block SHALL drive mem_wen = 1 and mem_wdata = wdata, then return to IDLE; rsp_valid is high at acceptance + 2.
REQ-024 Byte/half store in ACCESS: the block SHALL register mem_rdata merged with wdata[7:0] or wdata[15:0] in the addressed lane, with mem_wen = 0, then enter WRITE.
REQ-025 WRITE: the block SHALL drive mem_wen = 1 and mem_wdata = the merged word, then return to IDLE; rsp_valid is high at acceptance + 3.
REQ-026 mem_wen SHALL be 0 in IDLE, in load ACCESS, and in sub-word-store ACCESS.
REQ-027 IDLE SHALL accept a new request in the same cycle rsp_valid is high (back-to-back throughput: 2 cycles per load/word store, 3 per sub-word store).
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid; rsp_rdata SHALL be 0 for stores.
REQ-029 req_* inputs SHALL be ignored outside the accepting cycle.

Reset
REQ-030 Asserting rst SHALL immediately force state IDLE, mem_wen = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and all registered request fields = 0.
REQ-031 Reset mid-operation SHALL drop the in-flight request with no write and no response; req_ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-032 With DMEM_CTRL_MISALIGN_CHECK_EN defined, a request SHALL be misaligned when it is a half with addr[0] = 1, or a word/reserved size with addr[1:0] != 0.
REQ-033 With DMEM_CTRL_MISALIGN_CHECK_EN defined, a misaligned request SHALL perform no memory write, complete at acceptance + 2 with rsp_err = 1 and rsp_rdata = 0, and leave memory unchanged.
REQ-034 Without DMEM_CTRL_MISALIGN_CHECK_EN, rsp_err SHALL be constant 0, word accesses SHALL ignore addr[1:0], and half accesses SHALL ignore addr[0].

Verification
REQ-035 Word 0x00000040 = 0x8899AABB; load byte at 0x41, signed -> rsp_rdata = 0xFFFFFFAA at acceptance + 2; the same load unsigned -> 0x000000AA.
REQ-036 Store byte 0x5C to 0x43 over 0x8899AABB -> exactly one mem_wen pulse at acceptance + 2 with mem_waddr = 0x010 and mem_wdata = 0x5C99AABB; rsp_valid at acceptance + 3.
REQ-037 Store word 0x12345678 to 0x8, then load half unsigned from 0xA -> 0x00001234; req_valid is held continuously and the second request is accepted in the first store's rsp_valid cycle.
REQ-038 With DMEM_CTRL_MISALIGN_CHECK_EN, store word to 0x6 -> mem_wen never asserted, rsp_err = 1, rsp_rdata = 0; without the macro, the same store writes word address 0x001.
REQ-039 Assert rst while in WRITE of a half store -> mem_wen drops to 0 immediately, no rsp_valid, target word unchanged, req_ready = 1 in the first cycle after rst deasserts.
REQ-040 Store word to 0x00004000 with ADDR_WIDTH = 12 -> mem_waddr wraps to 0x000.
